// File: rtl/wb_arbiter.sv
// wb_arbiter: write-side master for the register file. Merges single-cycle
// ALU results with queued load returns onto one registered write port and
// keeps a per-register busy scoreboard so decode can stall on pending loads.
module wb_arbiter #(
  parameter int LD_DEPTH = 2,
  parameter int DW       = 16,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] issue_dest,
  input  logic [AW-1:0] chk_addr_1,
  input  logic [AW-1:0] chk_addr_2,
  output logic          hazard,
  output logic          reg_wr_en,
  output logic [AW-1:0] reg_wr_dest,
  output logic [DW-1:0] reg_wr_data,
  output logic          err
);

  localparam int PW   = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int NREG = 1 << AW;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LD_DEPTH);

  // Load-return queue storage and bookkeeping
  logic [AW-1:0]   fifo_dest [LD_DEPTH];
  logic [DW-1:0]   fifo_data [LD_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;

  // Scoreboard and write-source tag for the registered write
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_ld;

  // Per-cycle decisions
  logic            alu_sel;
  logic            mem_acc;
  logic            push;
  logic            pop;
  logic            issue_set;

  // Handshakes, source selection and hazard lookup
  always_comb begin
    mem_ready   = (count < FULL_CNT);
    issue_ready = ~busy[issue_dest];
    hazard      = busy[chk_addr_1] | busy[chk_addr_2];
    alu_sel     = alu_valid & (alu_dest != '0);
    mem_acc     = mem_valid & mem_ready;
    push        = mem_acc & (mem_dest != '0);
    pop         = ~alu_sel & (count != '0);
    issue_set   = issue_valid & issue_ready & (issue_dest != '0);
  end

  // Next busy vector: a load write retires its bit as the register file commits,
  // and an accepted issue claims its destination for the next cycle
  always_comb begin
    busy_nxt = busy;
    if (reg_wr_en && wr_ld) busy_nxt[reg_wr_dest] = 1'b0;
    if (issue_set)          busy_nxt[issue_dest]  = 1'b1;
  end

  // Queue payload storage; only the pointers/count need resetting
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= mem_dest;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Registered write port, queue pointers, scoreboard and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en   <= 1'b0;
      reg_wr_dest <= '0;
      reg_wr_data <= '0;
      wr_ld       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      busy        <= '0;
      err         <= 1'b0;
    end else begin
      reg_wr_en <= alu_sel | pop;
      wr_ld     <= pop;
      if (alu_sel) begin
        reg_wr_dest <= alu_dest;
        reg_wr_data <= alu_data;
      end else if (pop) begin
        reg_wr_dest <= fifo_dest[rd_ptr];
        reg_wr_data <= fifo_data[rd_ptr];
      end
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      busy <= busy_nxt;
      if (push && !busy[mem_dest]) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the write-back arbiter.
module tb_wb_arbiter;

  localparam int LD_DEPTH = 2;
  localparam int DW       = 16;
  localparam int AW       = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          issue_valid;
  logic          issue_ready;
  logic [AW-1:0] issue_dest;
  logic [AW-1:0] chk_addr_1;
  logic [AW-1:0] chk_addr_2;
  logic          hazard;
  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_dest;
  logic [DW-1:0] reg_wr_data;
  logic          err;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [AW-1:0] mq_dest [$];
  logic [DW-1:0] mq_data [$];
  bit   [7:0]    m_busy;
  bit            m_en, m_ld, m_err;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;

  wb_arbiter #(.LD_DEPTH(LD_DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dest(issue_dest),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2), .hazard(hazard),
    .reg_wr_en(reg_wr_en), .reg_wr_dest(reg_wr_dest), .reg_wr_data(reg_wr_data),
    .err(err)
  );

  always #5 clk = ~clk;

  // Apply one clock edge to the model using the inputs the DUT samples
  task automatic model_edge();
    bit [7:0] nb;
    bit       acc;
    if (rst) begin
      mq_dest.delete(); mq_data.delete();
      m_busy = '0; m_en = 0; m_ld = 0; m_err = 0; m_dest = '0; m_data = '0;
      return;
    end
    nb = m_busy;
    if (m_en && m_ld) nb[m_dest] = 1'b0;
    if (issue_valid && !m_busy[issue_dest] && issue_dest != 0) nb[issue_dest] = 1'b1;
    acc = mem_valid && (mq_dest.size() < LD_DEPTH);
    if (alu_valid && alu_dest != 0) begin
      m_en = 1; m_ld = 0; m_dest = alu_dest; m_data = alu_data;
    end else if (mq_dest.size() > 0) begin
      m_en = 1; m_ld = 1; m_dest = mq_dest.pop_front(); m_data = mq_data.pop_front();
    end else begin
      m_en = 0; m_ld = 0;
    end
    if (acc && mem_dest != 0) begin
      if (!m_busy[mem_dest]) m_err = 1;
      mq_dest.push_back(mem_dest);
      mq_data.push_back(mem_data);
    end
    m_busy = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; alu_valid = 0; alu_dest = '0; alu_data = '0;
    mem_valid = 0; mem_dest = '0; mem_data = '0;
    issue_valid = 0; issue_dest = '0; chk_addr_1 = '0; chk_addr_2 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h1111;
    chk_addr_1 = 3'd3; chk_addr_2 = 3'd5;
    tick(); tick();
    checks++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL rst_en got %0b want 0", reg_wr_en); end
    checks++; if (reg_wr_dest !== 3'd0) begin fails++; $display("FAIL rst_dest got %0h want 0", reg_wr_dest); end
    checks++; if (reg_wr_data !== 16'h0) begin fails++; $display("FAIL rst_data got %0h want 0", reg_wr_data); end
    checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL rst_hazard got %0b want 0", hazard); end
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL rst_mem_ready got %0b want 1", mem_ready); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %0b want 0", err); end
    rst = 0;
    tick();
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd3 || reg_wr_data !== 16'h1111) begin
      fails++; $display("FAIL rst_first_write got en=%0b d=%0h v=%0h want 1/3/1111", reg_wr_en, reg_wr_dest, reg_wr_data); end
  endtask

  task automatic test_alu();
    idle();
    alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h1234;
    tick();
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd3 || reg_wr_data !== 16'h1234) begin
      fails++; $display("FAIL alu_write got en=%0b d=%0h v=%0h want 1/3/1234", reg_wr_en, reg_wr_dest, reg_wr_data); end
    alu_dest = 3'd0; alu_data = 16'h5555;
    tick();
    checks++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL alu_r0_dropped got %0b want 0", reg_wr_en); end
    checks++; if (reg_wr_dest !== 3'd3 || reg_wr_data !== 16'h1234) begin
      fails++; $display("FAIL alu_hold got d=%0h v=%0h want 3/1234", reg_wr_dest, reg_wr_data); end
    idle();
  endtask

  task automatic test_load_scoreboard();
    idle();
    issue_valid = 1; issue_dest = 3'd5; chk_addr_1 = 3'd5;
    #1;
    checks++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL ld_issue_ready got %0b want 1", issue_ready); end
    checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL ld_same_cycle_hazard got %0b want 0", hazard); end
    tick();
    issue_valid = 0;
    #1;
    checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL ld_busy_hazard got %0b want 1", hazard); end
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL ld_busy_issue_ready got %0b want 0", issue_ready); end
    mem_valid = 1; mem_dest = 3'd5; mem_data = 16'hBEEF;
    #1;
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL ld_mem_ready got %0b want 1", mem_ready); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (reg_wr_en !== 1'b0 || hazard !== 1'b1) begin
      fails++; $display("FAIL ld_n1 got en=%0b hz=%0b want 0/1", reg_wr_en, hazard); end
    tick();
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd5 || reg_wr_data !== 16'hBEEF || hazard !== 1'b1) begin
      fails++; $display("FAIL ld_n2 got en=%0b d=%0h v=%0h hz=%0b want 1/5/beef/1", reg_wr_en, reg_wr_dest, reg_wr_data, hazard); end
    tick();
    checks++; if (hazard !== 1'b0 || reg_wr_en !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL ld_n3 got hz=%0b en=%0b err=%0b want 0/0/0", hazard, reg_wr_en, err); end
  endtask

  task automatic test_contention();
    idle();
    issue_valid = 1; issue_dest = 3'd2;
    tick();
    issue_valid = 0;
    mem_valid = 1; mem_dest = 3'd2; mem_data = 16'h2222;
    alu_valid = 1; alu_dest = 3'd1; alu_data = 16'hA001;
    tick();
    mem_valid = 0; alu_dest = 3'd4; alu_data = 16'hA004;
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd1 || reg_wr_data !== 16'hA001) begin
      fails++; $display("FAIL cont_alu1 got en=%0b d=%0h v=%0h want 1/1/a001", reg_wr_en, reg_wr_dest, reg_wr_data); end
    tick();
    alu_dest = 3'd6; alu_data = 16'hA006;
    checks++; if (reg_wr_dest !== 3'd4 || reg_wr_data !== 16'hA004) begin
      fails++; $display("FAIL cont_alu4 got d=%0h v=%0h want 4/a004", reg_wr_dest, reg_wr_data); end
    tick();
    alu_valid = 0;
    checks++; if (reg_wr_dest !== 3'd6 || reg_wr_data !== 16'hA006) begin
      fails++; $display("FAIL cont_alu6 got d=%0h v=%0h want 6/a006", reg_wr_dest, reg_wr_data); end
    issue_valid = 1; issue_dest = 3'd2;
    #1;
    checks++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL cont_issue_busy got %0b want 0", issue_ready); end
    tick();
    issue_valid = 0;
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd2 || reg_wr_data !== 16'h2222 || m_ld !== 1'b1) begin
      fails++; $display("FAIL cont_load got en=%0b d=%0h v=%0h want 1/2/2222", reg_wr_en, reg_wr_dest, reg_wr_data); end
    chk_addr_1 = 3'd2; chk_addr_2 = 3'd2;
    #1;
    checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL cont_hazard_commit got %0b want 1", hazard); end
    tick();
    checks++; if (hazard !== 1'b0 || reg_wr_en !== 1'b0) begin
      fails++; $display("FAIL cont_cleared got hz=%0b en=%0b want 0/0", hazard, reg_wr_en); end
  endtask

  task automatic test_fifo_full();
    idle();
    issue_valid = 1; issue_dest = 3'd3; tick();
    issue_dest = 3'd4; tick();
    issue_valid = 0;
    alu_valid = 1; alu_dest = 3'd1; alu_data = 16'h0101;
    mem_valid = 1; mem_dest = 3'd3; mem_data = 16'h3333; tick();
    mem_dest = 3'd4; mem_data = 16'h4444; tick();
    mem_dest = 3'd0; mem_data = 16'h0BAD;
    #1;
    checks++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b want 0", mem_ready); end
    tick();
    checks++; if (mem_ready !== 1'b0 || reg_wr_dest !== 3'd1) begin
      fails++; $display("FAIL full_held got rdy=%0b d=%0h want 0/1", mem_ready, reg_wr_dest); end
    alu_valid = 0;
    #1;
    checks++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready got %0b want 0", mem_ready); end
    tick();
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd3 || reg_wr_data !== 16'h3333) begin
      fails++; $display("FAIL full_drain1 got en=%0b d=%0h v=%0h want 1/3/3333", reg_wr_en, reg_wr_dest, reg_wr_data); end
    checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL full_ready_back got %0b want 1", mem_ready); end
    tick();
    mem_valid = 0;
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd4 || reg_wr_data !== 16'h4444) begin
      fails++; $display("FAIL full_drain2 got en=%0b d=%0h v=%0h want 1/4/4444", reg_wr_en, reg_wr_dest, reg_wr_data); end
    tick();
    checks++; if (reg_wr_en !== 1'b0 || mem_ready !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL full_r0_load got en=%0b rdy=%0b err=%0b want 0/1/0", reg_wr_en, mem_ready, err); end
  endtask

  task automatic test_err_reset();
    idle();
    mem_valid = 1; mem_dest = 3'd7; mem_data = 16'h7777;
    tick();
    mem_valid = 0;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %0b want 1", err); end
    tick();
    checks++; if (reg_wr_en !== 1'b1 || reg_wr_dest !== 3'd7 || reg_wr_data !== 16'h7777) begin
      fails++; $display("FAIL err_write got en=%0b d=%0h v=%0h want 1/7/7777", reg_wr_en, reg_wr_dest, reg_wr_data); end
    issue_valid = 1; issue_dest = 3'd3; tick();
    issue_dest = 3'd4; tick();
    issue_valid = 0;
    alu_valid = 1; alu_dest = 3'd1; alu_data = 16'h0111;
    mem_valid = 1; mem_dest = 3'd3; mem_data = 16'h3030; tick();
    mem_dest = 3'd4; mem_data = 16'h4040; tick();
    alu_valid = 0; mem_valid = 0; chk_addr_1 = 3'd3; chk_addr_2 = 3'd4;
    #1;
    checks++; if (hazard !== 1'b1 || mem_ready !== 1'b0) begin
      fails++; $display("FAIL err_prerst got hz=%0b rdy=%0b want 1/0", hazard, mem_ready); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (reg_wr_en !== 1'b0 || err !== 1'b0 || hazard !== 1'b0 || mem_ready !== 1'b1) begin
      fails++; $display("FAIL midrst got en=%0b err=%0b hz=%0b rdy=%0b want 0/0/0/1", reg_wr_en, err, hazard, mem_ready); end
    tick();
    checks++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL midrst_drain1 got %0b want 0", reg_wr_en); end
    tick();
    checks++; if (reg_wr_en !== 1'b0) begin fails++; $display("FAIL midrst_drain2 got %0b want 0", reg_wr_en); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_dest    = AW'($urandom_range(0, 7));
      alu_data    = DW'($urandom);
      mem_valid   = ($urandom_range(0, 1) == 1);
      mem_dest    = AW'($urandom_range(0, 7));
      mem_data    = DW'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_dest  = AW'($urandom_range(0, 7));
      chk_addr_1  = AW'($urandom_range(0, 7));
      chk_addr_2  = AW'($urandom_range(0, 7));
      #1;
      checks++; if (mem_ready !== (mq_dest.size() < LD_DEPTH)) begin
        fails++; $display("FAIL rnd_mem_ready cyc %0d got %0b want %0b", i, mem_ready, mq_dest.size() < LD_DEPTH); end
      checks++; if (issue_ready !== !m_busy[issue_dest]) begin
        fails++; $display("FAIL rnd_issue_ready cyc %0d got %0b want %0b", i, issue_ready, !m_busy[issue_dest]); end
      checks++; if (hazard !== (m_busy[chk_addr_1] | m_busy[chk_addr_2])) begin
        fails++; $display("FAIL rnd_hazard cyc %0d got %0b want %0b", i, hazard, m_busy[chk_addr_1] | m_busy[chk_addr_2]); end
      tick();
      checks++; if (reg_wr_en !== m_en) begin
        fails++; $display("FAIL rnd_en cyc %0d got %0b want %0b", i, reg_wr_en, m_en); end
      checks++; if (reg_wr_dest !== m_dest || reg_wr_data !== m_data) begin
        fails++; $display("FAIL rnd_wr cyc %0d got d=%0h v=%0h want d=%0h v=%0h", i, reg_wr_dest, reg_wr_data, m_dest, m_data); end
      checks++; if (err !== m_err) begin
        fails++; $display("FAIL rnd_err cyc %0d got %0b want %0b", i, err, m_err); end
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_load_scoreboard();
    test_contention();
    test_fifo_full();
    test_err_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
